dmem_arbiter: RTL and testbench

- Shares the single data-memory port (the `memory` block's ren/wen/data_addr/data_in/byte_select_vector/data_out/ready) between two bus masters.
- Master 0 is the CPU data port. Master 1 is a DMA/loader engine, for example a PPU refill or program-memory loader.
- Sits between `bus` and `memory`. Performs round-robin (or fixed-priority) arbitration, latches the command, waits for memory `ready`, and returns registered read data with a one-cycle completion pulse.
- A timeout counter guarantees completion if memory never asserts ready.

---
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-master arbiter sharing the single data-memory port.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW         = 30,
    parameter int TIMEOUT    = 255,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        m_req,
    input  logic [1:0]        m_wen,
    input  logic [2*AW-1:0]   m_addr,
    input  logic [63:0]       m_wdata,
    input  logic [7:0]        m_bsel,
    output logic [31:0]       m_rdata,
    output logic [1:0]        m_ready,
    output logic [1:0]        m_err,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [AW-1:0]     mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_bsel,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              wen_q, wen_d;
    logic              err_q, err_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [3:0]        bsel_q, bsel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              pick;
    logic              timeout_hit;
    logic [1:0]        owner_onehot;

    // Ties go to the master that did not win last time unless priority is fixed.
    always_comb begin
        pick = 1'b0;
        case (m_req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
            default: pick = 1'b0;
        endcase
    end

    assign timeout_hit  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign owner_onehot = owner_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        wen_d   = wen_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        bsel_d  = bsel_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|m_req) begin
                    owner_d = pick;
                    last_d  = pick;
                    wen_d   = pick ? m_wen[1]          : m_wen[0];
                    addr_d  = pick ? m_addr[2*AW-1:AW] : m_addr[AW-1:0];
                    wdata_d = pick ? m_wdata[63:32]    : m_wdata[31:0];
                    bsel_d  = pick ? m_bsel[7:4]       : m_bsel[3:0];
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // A ready arriving on the timeout cycle still counts as success.
                if (mem_ready) begin
                    if (!wen_q) begin
                        rdata_d = mem_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            bsel_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            bsel_q  <= bsel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes decode straight from the registered state so reset kills them at once.
    assign mem_ren   = (state_q == ST_ACCESS) && !wen_q;
    assign mem_wen   = (state_q == ST_ACCESS) &&  wen_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_bsel  = bsel_q;
    assign m_rdata   = rdata_q;
    assign m_ready   = (state_q == ST_RESP) ? owner_onehot : 2'b00;
    assign m_err     = ((state_q == ST_RESP) && err_q) ? owner_onehot : 2'b00;
    assign grant     = (state_q != ST_IDLE) ? owner_onehot : 2'b00;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Round-robin and fixed-priority arbiters checked against a
//            transaction-level model under directed and random traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW = 30;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [1:0]      m_req = '0;
    logic [1:0]      m_wen = '0;
    logic [2*AW-1:0] m_addr = '0;
    logic [63:0]     m_wdata = '0;
    logic [7:0]      m_bsel = '0;
    logic [31:0]     mem_rdata = '0;
    logic            mem_ready = 1'b0;

    // Index 0: round-robin, TIMEOUT=8.  Index 1: fixed priority, TIMEOUT=4.
    logic [31:0]     o_rdata [2];
    logic [1:0]      o_ready [2];
    logic [1:0]      o_err   [2];
    logic            o_ren   [2];
    logic            o_wen   [2];
    logic [AW-1:0]   o_maddr [2];
    logic [31:0]     o_mwdata[2];
    logic [3:0]      o_mbsel [2];
    logic [1:0]      o_grant [2];
    logic            o_busy  [2];

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .TIMEOUT(8), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_bsel(m_bsel),
        .m_rdata(o_rdata[0]), .m_ready(o_ready[0]), .m_err(o_err[0]),
        .mem_ren(o_ren[0]), .mem_wen(o_wen[0]), .mem_addr(o_maddr[0]),
        .mem_wdata(o_mwdata[0]), .mem_bsel(o_mbsel[0]),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(o_grant[0]), .busy(o_busy[0])
    );

    dmem_arbiter #(.AW(AW), .TIMEOUT(4), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_bsel(m_bsel),
        .m_rdata(o_rdata[1]), .m_ready(o_ready[1]), .m_err(o_err[1]),
        .mem_ren(o_ren[1]), .mem_wen(o_wen[1]), .mem_addr(o_maddr[1]),
        .mem_wdata(o_mwdata[1]), .mem_bsel(o_mbsel[1]),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(o_grant[1]), .busy(o_busy[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int            to_lim[2] = '{8, 4};
    bit            fixed_p[2] = '{1'b0, 1'b1};
    bit            md_in_mem[2];
    bit            md_reply[2];
    int            md_owner[2];
    int            md_last[2];
    int            md_waited[2];
    bit            md_write[2];
    bit            md_err[2];
    logic [AW-1:0] md_addr[2];
    logic [31:0]   md_wdata[2];
    logic [31:0]   md_rdata[2];
    logic [3:0]    md_bsel[2];

    function automatic int choose(input logic [1:0] req, input bit fp, input int last);
        if (req == 2'b11) return fp ? 0 : 1 - last;
        return req[1] ? 1 : 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                md_in_mem[k] = 0; md_reply[k] = 0; md_owner[k] = 0; md_last[k] = 1;
                md_waited[k] = 0; md_write[k] = 0; md_err[k] = 0;
                md_addr[k] = '0; md_wdata[k] = '0; md_rdata[k] = '0; md_bsel[k] = '0;
            end else if (md_reply[k]) begin
                md_reply[k] = 0;
            end else if (md_in_mem[k]) begin
                if (mem_ready) begin
                    if (!md_write[k]) md_rdata[k] = mem_rdata;
                    md_err[k] = 0; md_in_mem[k] = 0; md_reply[k] = 1;
                end else if (to_lim[k] != 0 && md_waited[k] + 1 == to_lim[k]) begin
                    md_err[k] = 1; md_in_mem[k] = 0; md_reply[k] = 1;
                end else begin
                    md_waited[k]++;
                end
            end else if (m_req != 2'b00) begin
                md_owner[k]  = choose(m_req, fixed_p[k], md_last[k]);
                md_last[k]   = md_owner[k];
                md_write[k]  = m_wen[md_owner[k]];
                md_addr[k]   = md_owner[k] == 1 ? m_addr[2*AW-1:AW] : m_addr[AW-1:0];
                md_wdata[k]  = md_owner[k] == 1 ? m_wdata[63:32] : m_wdata[31:0];
                md_bsel[k]   = md_owner[k] == 1 ? m_bsel[7:4] : m_bsel[3:0];
                md_waited[k] = 0;
                md_in_mem[k] = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                string nm;
                logic [1:0] oh;
                nm = (k == 0) ? "rr" : "fp";
                oh = (md_owner[k] == 1) ? 2'b10 : 2'b01;
                chk({nm, ".mem_ren"},   o_ren[k],    md_in_mem[k] && !md_write[k]);
                chk({nm, ".mem_wen"},   o_wen[k],    md_in_mem[k] && md_write[k]);
                chk({nm, ".mem_addr"},  o_maddr[k],  md_addr[k]);
                chk({nm, ".mem_wdata"}, o_mwdata[k], md_wdata[k]);
                chk({nm, ".mem_bsel"},  o_mbsel[k],  md_bsel[k]);
                chk({nm, ".m_rdata"},   o_rdata[k],  md_rdata[k]);
                chk({nm, ".m_ready"},   o_ready[k],  md_reply[k] ? oh : 2'b00);
                chk({nm, ".m_err"},     o_err[k],    (md_reply[k] && md_err[k]) ? oh : 2'b00);
                chk({nm, ".grant"},     o_grant[k],  (md_in_mem[k] || md_reply[k]) ? oh : 2'b00);
                chk({nm, ".busy"},      o_busy[k],   md_in_mem[k] || md_reply[k]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios + random traffic ----------------
    initial begin
        int wen_cnt[2], rdy_cyc[2], bad_stable;
        logic [1:0] rdy_val[2], err_val[2];
        logic [31:0] rd_val[2];
        int p_cnt[2], p_own[2][8], p_time[2][8], fp_g1;

        reset = 1'b1;
        step(); step();
        @(negedge clk);
        chk("reset.grant",    o_grant[0], 2'b00);
        chk("reset.busy",     o_busy[0],  1'b0);
        chk("reset.mem_ren",  o_ren[1],   1'b0);
        chk("reset.m_ready",  o_ready[0], 2'b00);
        chk("reset.mem_addr", o_maddr[0], 0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        step();

        // Single zero-wait read by master 0.
        m_req = 2'b01; m_wen = 2'b00; m_addr[AW-1:0] = 30'h10;
        step();
        m_req = 2'b00; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1.mem_ren_on", o_ren[0],   1'b1);
        chk("t1.mem_addr",   o_maddr[0], 30'h10);
        chk("t1.grant",      o_grant[0], 2'b01);
        step();
        mem_ready = 1'b0; mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("t1.m_ready",     o_ready[0], 2'b01);
        chk("t1.m_rdata",     o_rdata[0], 32'hDEADBEEF);
        chk("t1.m_err",       o_err[0],   2'b00);
        chk("t1.mem_ren_off", o_ren[0],   1'b0);
        step();
        @(negedge clk);
        chk("t1.idle_busy", o_busy[0], 1'b0);
        step();

        // Master 1 write, ready after 5 wait cycles: rr completes, fp (TIMEOUT=4) times out.
        m_req = 2'b10; m_wen = 2'b10; m_addr[2*AW-1:AW] = 30'h2AB;
        m_wdata[63:32] = 32'h12345678; m_bsel[7:4] = 4'b0011;
        step();
        m_req = 2'b00;
        bad_stable = 0;
        for (int k = 0; k < 2; k++) begin
            wen_cnt[k] = 0; rdy_cyc[k] = -1; rdy_val[k] = '0; err_val[k] = '0; rd_val[k] = '0;
        end
        for (int i = 1; i <= 10; i++) begin
            mem_ready = (i == 6);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (o_wen[k]) begin
                    wen_cnt[k]++;
                    if (o_maddr[k] != 30'h2AB || o_mwdata[k] != 32'h12345678 || o_mbsel[k] != 4'b0011)
                        bad_stable++;
                end
                if (o_ready[k] != 2'b00) begin
                    rdy_cyc[k] = i; rdy_val[k] = o_ready[k]; err_val[k] = o_err[k]; rd_val[k] = o_rdata[k];
                end
            end
            step();
        end
        mem_ready = 1'b0;
        chk("t4.rr_wen_cycles", wen_cnt[0], 6);
        chk("t4.stable",        bad_stable, 0);
        chk("t4.rr_ready_cyc",  rdy_cyc[0], 7);
        chk("t4.rr_ready",      rdy_val[0], 2'b10);
        chk("t4.rr_err",        err_val[0], 2'b00);
        chk("t4.rr_rdata",      rd_val[0],  32'hDEADBEEF);
        chk("t5.fp_wen_cycles", wen_cnt[1], 4);
        chk("t5.fp_ready_cyc",  rdy_cyc[1], 5);
        chk("t5.fp_ready",      rdy_val[1], 2'b10);
        chk("t5.fp_err",        err_val[1], 2'b10);
        chk("t5.fp_rdata",      rd_val[1],  32'hDEADBEEF);

        // Both masters requesting continuously, zero-wait memory.
        m_req = 2'b11; m_wen = 2'b00; mem_ready = 1'b1;
        m_addr = {30'h111, 30'h222};
        for (int k = 0; k < 2; k++) p_cnt[k] = 0;
        fp_g1 = 0;
        for (int i = 0; i <= 12; i++) begin
            mem_rdata = $urandom;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (o_ready[k] != 2'b00 && p_cnt[k] < 8) begin
                    p_own[k][p_cnt[k]]  = o_ready[k][1] ? 1 : 0;
                    p_time[k][p_cnt[k]] = i;
                    p_cnt[k]++;
                end
            end
            if (o_grant[1][1]) fp_g1++;
            step();
        end
        m_req = 2'b00;
        repeat (4) step();
        mem_ready = 1'b0;
        chk("t2.rr_pulses", p_cnt[0] >= 4, 1);
        if (p_cnt[0] >= 4) begin
            chk("t2.rr_first_time", p_time[0][0], 2);
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("t2.rr_owner%0d", j), p_own[0][j], j % 2);
                if (j > 0) chk($sformatf("t2.rr_gap%0d", j), p_time[0][j] - p_time[0][j-1], 3);
            end
        end
        chk("t3.fp_pulses",     p_cnt[1] >= 4, 1);
        chk("t3.fp_grant1",     fp_g1, 0);
        if (p_cnt[1] >= 1) chk("t3.fp_owner0", p_own[1][0], 0);

        // Reset in the middle of an access.
        m_req = 2'b01; m_wen = 2'b00; m_addr[AW-1:0] = 30'h33;
        step();
        m_req = 2'b00;
        @(negedge clk);
        chk("t6.ren_before", o_ren[0], 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t6.rr_ren",   o_ren[0],   1'b0);
        chk("t6.fp_ren",   o_ren[1],   1'b0);
        chk("t6.rr_grant", o_grant[0], 2'b00);
        chk("t6.rr_busy",  o_busy[0],  1'b0);
        step();
        @(negedge clk);
        chk("t6.no_ready", o_ready[0], 2'b00);
        step();
        reset = 1'b0; m_req = 2'b11;
        step();
        m_req = 2'b00; mem_ready = 1'b1;
        @(negedge clk);
        chk("t6.rr_tie_grant", o_grant[0], 2'b01);
        chk("t6.fp_tie_grant", o_grant[1], 2'b01);
        repeat (3) step();

        // Random traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 3000; i++) begin
            m_req     = 2'($urandom_range(0, 3));
            m_wen     = 2'($urandom_range(0, 3));
            m_addr    = {30'($urandom), 30'($urandom)};
            m_wdata   = {$urandom, $urandom};
            m_bsel    = 8'($urandom);
            mem_rdata = $urandom;
            mem_ready = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                #1 reset = 1'b0;
            end
            step();
        end
        m_req = 2'b00; mem_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
